// File: rtl/regfile_pkg.sv
// ============================================================
// regfile_pkg: register file write-port widths and request type
// Rev 1.0
// ============================================================
`default_nettype none

package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
// ============================================================
// regfile_write_arbiter_if: requester, regfile and status signals
// Rev 1.0
// ============================================================
`default_nettype none

interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              a_wr;
  logic [ADDR_W-1:0] a_rw;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rw;
  logic [DATA_W-1:0] b_data;
  logic              RegWr;
  logic [ADDR_W-1:0] Rw;
  logic [DATA_W-1:0] Data_in;
  logic              stall_req;
  logic [CNT_W-1:0]  q_count;

  modport master (
    output a_wr, a_rw, a_data, b_valid, b_rw, b_data,
    input  b_ready, RegWr, Rw, Data_in, stall_req, q_count
  );

  modport slave (
    input  a_wr, a_rw, a_data, b_valid, b_rw, b_data,
    output b_ready, RegWr, Rw, Data_in, stall_req, q_count
  );

endinterface

`default_nettype wire

// File: rtl/wr_fifo.sv
// ============================================================
// wr_fifo: DEPTH-entry FIFO of write requests, registered count
// Rev 1.0
// ============================================================
`default_nettype none

module wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wr_req_t          push_data,
  input  logic             pop,
  output wr_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_req_t          mem_q [DEPTH];
  wr_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================
// regfile_write_arbiter: writeback (A) over queued mul/div (B)
// Rev 1.0 | optional feature macro: REGFILE_ZERO_PROTECT_EN
// ============================================================
`default_nettype none

module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  wr_req_t           push_req;
  wr_req_t           head;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              a_act, b_take, b_ready_w, push, pop;
  logic              regwr_w;
  logic [ADDR_W-1:0] rw_w;
  logic [DATA_W-1:0] data_w;

  logic              out_en_q, out_en_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              stall_req_q, stall_req_d;

  // Reset gates Port A so the write port is quiet while rst is low.
`ifdef REGFILE_ZERO_PROTECT_EN
  assign a_act  = bus.a_wr && rst && (bus.a_rw != '0);
  assign b_take = (bus.b_rw != '0);
`else
  assign a_act  = bus.a_wr && rst;
  assign b_take = 1'b1;
`endif

  assign b_ready_w     = out_en_q && !fifo_full;
  assign push          = bus.b_valid && b_ready_w && b_take;
  assign push_req.rw   = bus.b_rw;
  assign push_req.data = bus.b_data;

  wr_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    regwr_w = 1'b0;
    rw_w    = '0;
    data_w  = '0;
    pop     = 1'b0;
    if (a_act) begin
      regwr_w = 1'b1;
      rw_w    = bus.a_rw;
      data_w  = bus.a_data;
    end else if (!fifo_empty) begin
      regwr_w = 1'b1;
      rw_w    = head.rw;
      data_w  = head.data;
      pop     = 1'b1;
    end
  end

  always_comb begin
    out_en_d   = 1'b1;
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || pop) begin
      wait_cnt_d = '0;
    end else if (a_act && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    stall_req_d = (wait_cnt_d == WAIT_W'(MAX_WAIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en_q    <= 1'b0;
      wait_cnt_q  <= '0;
      stall_req_q <= 1'b0;
    end else begin
      out_en_q    <= out_en_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign bus.b_ready   = b_ready_w;
  assign bus.RegWr     = regwr_w;
  assign bus.Rw        = rw_w;
  assign bus.Data_in   = data_w;
  assign bus.stall_req = stall_req_q;
  assign bus.q_count   = fifo_count;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================
// tb_regfile_write_arbiter: directed cycle vectors plus reset/r0 sequences
// Rev 1.0
// ============================================================
`default_nettype none

module tb_regfile_write_arbiter;

  typedef struct {
    logic        a_wr;
    logic [4:0]  a_rw;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rw;
    logic [31:0] b_data;
    logic        e_wr;
    logic [4:0]  e_rw;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_stall;
    logic [1:0]  e_q;
  } vec_t;

  localparam int NVEC = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) bus ();

  regfile_write_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .DEPTH    (2),
    .MAX_WAIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                              input logic bv, input logic [4:0] br, input logic [31:0] bd,
                              input logic ew, input logic [4:0] er, input logic [31:0] ed,
                              input logic ery, input logic es, input logic [1:0] eq);
    vec_t v;
    v.a_wr = aw; v.a_rw = ar; v.a_data = ad;
    v.b_valid = bv; v.b_rw = br; v.b_data = bd;
    v.e_wr = ew; v.e_rw = er; v.e_data = ed;
    v.e_rdy = ery; v.e_stall = es; v.e_q = eq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    bus.a_wr = aw; bus.a_rw = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_rw = br; bus.b_data = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cycle-by-cycle: inputs, then expected RegWr/Rw/Data_in/b_ready/stall_req/q_count
    vecs[0]  = mk(0, 0,  0,            0, 0, 0,     0, 0,  0,            1, 0, 0);
    vecs[1]  = mk(1, 7,  32'hDEADBEEF, 0, 0, 0,     1, 7,  32'hDEADBEEF, 1, 0, 0);
    vecs[2]  = mk(0, 0,  0,            1, 3, 32'h12, 0, 0, 0,            1, 0, 0);
    vecs[3]  = mk(0, 0,  0,            0, 0, 0,     1, 3,  32'h12,       1, 0, 1);
    vecs[4]  = mk(0, 0,  0,            0, 0, 0,     0, 0,  0,            1, 0, 0);
    vecs[5]  = mk(0, 0,  0,            1, 5, 32'h55, 0, 0, 0,            1, 0, 0);
    vecs[6]  = mk(1, 9,  32'h99,       0, 0, 0,     1, 9,  32'h99,       1, 0, 1);
    vecs[7]  = mk(0, 0,  0,            0, 0, 0,     1, 5,  32'h55,       1, 0, 1);
    vecs[8]  = mk(0, 0,  0,            0, 0, 0,     0, 0,  0,            1, 0, 0);
    vecs[9]  = mk(1, 10, 32'hA0,       1, 1, 32'h01, 1, 10, 32'hA0,      1, 0, 0);
    vecs[10] = mk(1, 11, 32'hA1,       1, 2, 32'h02, 1, 11, 32'hA1,      1, 0, 1);
    vecs[11] = mk(1, 12, 32'hA2,       1, 4, 32'h04, 1, 12, 32'hA2,      0, 0, 2);
    vecs[12] = mk(0, 0,  0,            1, 4, 32'h04, 1, 1,  32'h01,      0, 0, 2);
    vecs[13] = mk(0, 0,  0,            1, 4, 32'h04, 1, 2,  32'h02,      1, 0, 1);
    vecs[14] = mk(0, 0,  0,            0, 0, 0,     1, 4,  32'h04,       1, 0, 1);
    vecs[15] = mk(0, 0,  0,            0, 0, 0,     0, 0,  0,            1, 0, 0);
    vecs[16] = mk(0, 0,  0,            1, 6, 32'h66, 0, 0, 0,            1, 0, 0);
    vecs[17] = mk(1, 13, 32'hB0,       0, 0, 0,     1, 13, 32'hB0,       1, 0, 1);
    vecs[18] = mk(1, 14, 32'hB1,       0, 0, 0,     1, 14, 32'hB1,       1, 0, 1);
    vecs[19] = mk(1, 15, 32'hB2,       0, 0, 0,     1, 15, 32'hB2,       1, 0, 1);
    vecs[20] = mk(1, 16, 32'hB3,       0, 0, 0,     1, 16, 32'hB3,       1, 0, 1);
    vecs[21] = mk(1, 17, 32'hB4,       0, 0, 0,     1, 17, 32'hB4,       1, 1, 1);
    vecs[22] = mk(0, 0,  0,            0, 0, 0,     1, 6,  32'h66,       1, 1, 1);
    vecs[23] = mk(0, 0,  0,            0, 0, 0,     0, 0,  0,            1, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    #3;
    check("reset_regwr",   32'(bus.RegWr),     32'd0);
    check("reset_b_ready", 32'(bus.b_ready),   32'd0);
    check("reset_stall",   32'(bus.stall_req), 32'd0);
    check("reset_q_count", 32'(bus.q_count),   32'd0);
    #9 rst = 1'b1;
    next_cycle();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].a_wr, vecs[i].a_rw, vecs[i].a_data,
            vecs[i].b_valid, vecs[i].b_rw, vecs[i].b_data);
      #2;
      check($sformatf("vec%0d_regwr", i),   32'(bus.RegWr),     32'(vecs[i].e_wr));
      check($sformatf("vec%0d_rw", i),      32'(bus.Rw),        32'(vecs[i].e_rw));
      check($sformatf("vec%0d_data", i),    bus.Data_in,        vecs[i].e_data);
      check($sformatf("vec%0d_b_ready", i), 32'(bus.b_ready),   32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_stall", i),   32'(bus.stall_req), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_q_count", i), 32'(bus.q_count),   32'(vecs[i].e_q));
      next_cycle();
    end

    // Mid-traffic reset with two entries queued
    drive(1, 20, 32'hC0, 1, 1, 32'hE1);
    next_cycle();
    drive(1, 21, 32'hC1, 1, 2, 32'hE2);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("prereset_q_count", 32'(bus.q_count), 32'd2);
    rst = 1'b0;
    #1;
    check("midreset_q_count", 32'(bus.q_count), 32'd0);
    check("midreset_regwr",   32'(bus.RegWr),   32'd0);
    check("midreset_rw",      32'(bus.Rw),      32'd0);
    check("midreset_data",    bus.Data_in,      32'd0);
    check("midreset_b_ready", 32'(bus.b_ready), 32'd0);
    next_cycle();
    #2 rst = 1'b1;
    next_cycle();
    check("postreset_b_ready", 32'(bus.b_ready), 32'd1);
    check("postreset_regwr",   32'(bus.RegWr),   32'd0);
    check("postreset_q_count", 32'(bus.q_count), 32'd0);
    next_cycle();
    check("postreset_regwr2",  32'(bus.RegWr),   32'd0);

    // Register 0 handling
`ifdef REGFILE_ZERO_PROTECT_EN
    drive(1, 0, 32'h5, 0, 0, 0);
    #2 check("r0_a_regwr", 32'(bus.RegWr), 32'd0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'h7);
    #2 check("r0_b_ready", 32'(bus.b_ready), 32'd1);
    next_cycle();
    drive(0, 0, 0, 1, 8, 32'h88);
    #2 check("r0_b_dropped_q", 32'(bus.q_count), 32'd0);
    check("r0_b_dropped_regwr", 32'(bus.RegWr), 32'd0);
    next_cycle();
    drive(1, 0, 32'h5, 0, 0, 0);
    #2 check("r0_drain_regwr", 32'(bus.RegWr), 32'd1);
    check("r0_drain_rw", 32'(bus.Rw), 32'd8);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #2 check("r0_drain_q", 32'(bus.q_count), 32'd0);
`else
    drive(1, 0, 32'h5, 0, 0, 0);
    #2 check("r0_a_regwr", 32'(bus.RegWr), 32'd1);
    check("r0_a_data", bus.Data_in, 32'h5);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'h7);
    #2 check("r0_b_ready", 32'(bus.b_ready), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #2 check("r0_b_regwr", 32'(bus.RegWr), 32'd1);
    check("r0_b_rw", 32'(bus.Rw), 32'd0);
    check("r0_b_data", bus.Data_in, 32'h7);
    next_cycle();
    #1 check("r0_b_q", 32'(bus.q_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
